// File: rtl/tcm_port_master.sv
// Request-stream initiator for one TCM RAM port. It drives the RAM in the issue cycle,
// captures the registered read data one cycle later, and returns tagged responses in order.
module tcm_port_master #(
    parameter int          TAG_W      = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RESP_DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [3:0]       req_wr_i,
    input  logic [31:0]      req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_accept_i,
    output logic [31:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_error_o,
    output logic [13:0]      ram_addr_o,
    output logic [63:0]      ram_data_o,
    output logic [7:0]       ram_wr_o,
    input  logic [63:0]      ram_data_i
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             error;
    } resp_t;

    logic [31:0]      offset;
    logic             in_range;
    logic             fire;
    logic             unused_ok;

    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_hi;
    logic             s1_write;
    logic             s1_error;

    resp_t            fifo_mem [RESP_DEPTH];
    resp_t            push_entry;
    resp_t            head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   outstanding;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign offset    = req_addr_i - BASE_ADDR;
    assign in_range  = (offset[31:17] == '0);
    assign unused_ok = ^offset[1:0];

    // Ready depends only on registered occupancy, so resp_accept_i never reaches req_ready_o.
    assign outstanding = {1'b0, count} + (CNT_W + 1)'(s1_valid);
    assign req_ready_o = !rst_i && (outstanding < (CNT_W + 1)'(RESP_DEPTH));
    assign fire        = req_valid_i & req_ready_o;

    assign ram_addr_o = offset[16:3];
    assign ram_data_o = {req_data_i, req_data_i};
    assign ram_wr_o   = (fire && in_range) ? (offset[2] ? {req_wr_i, 4'h0} : {4'h0, req_wr_i})
                                           : 8'h00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_hi    <= 1'b0;
            s1_write <= 1'b0;
            s1_error <= 1'b0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_tag   <= req_tag_i;
                s1_hi    <= offset[2];
                s1_write <= (req_wr_i != 4'h0);
                s1_error <= !in_range;
            end
        end
    end

    // RAM read data is valid only in the cycle after issue, so it is captured at push time.
    always_comb begin
        push_entry       = '0;
        push_entry.tag   = s1_tag;
        push_entry.error = s1_error;
        if (!(s1_error || s1_write))
            push_entry.data = s1_hi ? ram_data_i[63:32] : ram_data_i[31:0];
    end

    assign push = s1_valid;
    assign pop  = resp_valid_o & resp_accept_i;

    // NOTE: the entry storage has no reset; count gates every use of it, so stale contents are never visible.
    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head         = fifo_mem[rd_ptr];
    assign resp_valid_o = !rst_i && (count != '0);
    assign resp_data_o  = resp_valid_o ? head.data  : '0;
    assign resp_tag_o   = resp_valid_o ? head.tag   : '0;
    assign resp_error_o = resp_valid_o ? head.error : 1'b0;

endmodule
